// File: rtl/clk_step_ctrl.sv
// Single-step / run / burst clock-enable controller for a debug pipeline.
// Emits one-cycle tick pulses on in_clk; tick_count tracks all ticks issued.
module clk_step_ctrl #(
  parameter int unsigned DIV  = 20,
  parameter int unsigned BL_W = 16
) (
  input  logic            in_clk,
  input  logic            rst,
  input  logic            run_btn,
  input  logic            step_btn,
  input  logic            burst_btn,
  input  logic [BL_W-1:0] burst_len,
  input  logic            halt,
  output logic            tick,
  output logic [2:0]      state,
  output logic [31:0]     tick_count,
  output logic            burst_done
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    BURST  = 3'd2,
    HALTED = 3'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BL_W-1:0] rem_q, rem_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic [31:0]     tick_count_q, tick_count_d;
  logic            run_prev_q, step_prev_q, burst_prev_q;

  logic run_edge, step_edge, burst_edge, cnt_due;

  assign run_edge   = run_btn & ~run_prev_q;
  assign step_edge  = step_btn & ~step_prev_q;
  assign burst_edge = burst_btn & ~burst_prev_q;
  assign cnt_due    = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (run_edge) begin
          state_d = RUN;
        end else if (step_edge) begin
          // A step right after a burst's final tick is dropped to keep ticks apart.
          tick_d = ~tick_q;
        end else if (burst_edge && (burst_len != '0)) begin
          rem_d   = burst_len;
          state_d = BURST;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (run_edge) begin
          state_d = IDLE;
        end else if (cnt_due) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BURST: begin
        if (halt) begin
          state_d = HALTED;
        end else if (run_edge) begin
          state_d = IDLE;
        end else if (cnt_due) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          rem_d  = rem_q - BL_W'(1);
          if (rem_q == BL_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HALTED: begin
        if (run_edge && !halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    tick_count_d = tick_count_q + {31'd0, tick_d};
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      tick_count_q <= '0;
      run_prev_q   <= 1'b0;
      step_prev_q  <= 1'b0;
      burst_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      tick_count_q <= tick_count_d;
      run_prev_q   <= run_btn;
      step_prev_q  <= step_btn;
      burst_prev_q <= burst_btn;
    end
  end

  assign tick       = tick_q;
  assign state      = state_q;
  assign tick_count = tick_count_q;
  assign burst_done = done_q;

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 20: RUN/BURST tick period in in_clk cycles; legal range 2..65535.
REQ-002 SHALL have parameter BL_W, default 16: width of burst_len and of the remaining-tick counter.
REQ-003 SHALL have port in_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port run_btn  input  1  debounced level; a rising edge toggles run/pause, or clears halt.
REQ-006 SHALL have port step_btn  input  1  debounced level; a rising edge requests one tick.
REQ-007 SHALL have port burst_btn  input  1  debounced level; a rising edge starts a burst of burst_len ticks.
REQ-008 SHALL have port burst_len  input  BL_W  burst tick count, sampled only on a burst_btn rising edge.
REQ-009 SHALL have port halt  input  1  CPU halt request, level.
REQ-010 SHALL have port tick  output  1  registered one-cycle clock-enable pulse to the pipeline.
REQ-011 SHALL have port state  output  3  current state: IDLE=0, RUN=1, BURST=2, HALTED=3.
REQ-012 SHALL have port tick_count  output  32  total ticks issued; wraps 2^32-1 -> 0.
REQ-013 SHALL have port burst_done  output  1  registered one-cycle pulse when a burst completes.

Function
REQ-014 SHALL sample run_btn, step_btn and burst_btn into previous-value registers; a rising edge is the current value 1 with the previous value 0.
REQ-015 SHALL keep a divider counter cnt (0..DIV-1) that increments only in RUN or BURST and clears on every state change.
REQ-016 In RUN or BURST with cnt==DIV-1, SHALL set cnt to 0 and assert tick for the next cycle; the first tick appears DIV cycles after entry, then every DIV cycles.
REQ-017 SHALL resolve events in the same cycle by priority: halt > run edge > step edge > burst edge; lower-priority events in that cycle are discarded.
REQ-018 In IDLE, SHALL respond to events as follows:
- run edge: go to RUN.
- step edge: assert tick for exactly one cycle; state remains IDLE.
- burst edge with burst_len!=0: latch remaining=burst_len and go to BURST.
- burst edge with burst_len==0: ignored.
REQ-019 In RUN, a run edge SHALL return the block to IDLE with no tick issued in that transition cycle; step and burst edges are ignored.
REQ-020 In BURST, each issued tick SHALL decrement remaining; the tick issued when remaining==1 SHALL also go to IDLE and pulse burst_done in the same cycle as that tick.
REQ-021 In BURST, a run edge SHALL abort to IDLE with no burst_done pulse; step and burst edges are ignored.
REQ-022 In any state other than HALTED, halt==1 SHALL force HALTED next cycle and suppress any tick due that cycle.
REQ-023 In HALTED, SHALL issue no ticks and ignore step and burst edges; a run edge with halt==0 SHALL go to IDLE, and a run edge with halt==1 SHALL be ignored.
REQ-024 SHALL increment tick_count in the same cycle tick is asserted.
REQ-025 SHALL never assert tick on two consecutive cycles.

Reset
REQ-026 While rst=1, SHALL immediately set all of the following, regardless of in_clk:
- state=IDLE, cnt=0, remaining=0;
- tick=0, burst_done=0, tick_count=0;
- all edge-detect registers=0.
REQ-027 Reset asserted mid-RUN or mid-BURST SHALL abandon the operation with no burst_done; after release, the block SHALL stay in IDLE until a fresh button edge.
REQ-028 A button held high through reset release SHALL register as a rising edge on the first clock after release.

Verification
REQ-029 With DIV=4, a run edge at cycle 0 -> state=1 from cycle 1; tick high at cycles 5, 9 and 13; tick_count=3 after cycle 13.
REQ-030 In IDLE, three step edges 10 cycles apart -> exactly three single-cycle ticks, each one cycle after its edge; state stays 0.
REQ-031 With DIV=4 and burst_len=3 -> three ticks 4 cycles apart; burst_done coincides with the third tick; state returns to 0; a burst with burst_len=0 -> no ticks.
REQ-032 In RUN, halt=1 on the cycle a tick is due -> no tick, state=3; a run edge with halt=1 -> state stays 3; a run edge after halt drops -> state=0.
REQ-033 Same-cycle run and step edges in IDLE -> RUN entered, no step tick; rst asserted mid-BURST -> all outputs 0 immediately and no burst_done.
REQ-034 With tick_count preloaded via force to 0xFFFFFFFF, one step tick -> tick_count=0.
